gbt_tx_frameclk_pll_ctrl: RTL and testbench

GBT_TX_FRAMECLK_PLL_CTRL -- requirements
Module: gbt_tx_frameclk_pll_ctrl

---
 rtl/gbt_tx_frameclk_pll_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_gbt_tx_frameclk_pll_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gbt_tx_frameclk_pll_ctrl.sv
// ============================================================================
// gbt_tx_frameclk_pll_ctrl
//
// Purpose:
//   Sequences the TX frame-clock PLL. The controller pulses the PLL reset,
//   waits for lock with a timeout and bounded retries, and requires a run of
//   consecutive locked cycles before it declares the frame clock ready. It
//   restarts the sequence when lock is lost in READY, and parks in FAILED
//   with the PLL held in reset after MAX_RETRIES failed attempts. A software
//   relock request restarts the sequence from any state.
//
// Optional feature:
//   GBT_PLL_CTRL_LOL_COUNTER_EN -- when defined, lol_cnt_o counts
//   READY->RESET_PLL loss-of-lock events and saturates at 255. When it is
//   undefined, lol_cnt_o is tied to zero.
//
// Ports:
//   refclk        in   free-running controller clock (rising edge)
//   rst           in   synchronous active-high reset
//   locked_i      in   PLL lock indicator, asynchronous to refclk
//   relock_req_i  in   single-cycle request to restart the PLL sequence
//   pll_rst_o     out  PLL reset (high in RESET_PLL and FAILED)
//   ready_o       out  frame clock valid (high in READY)
//   error_o       out  lock failed after MAX_RETRIES attempts
//   state_o       out  current state code (3 bits)
//   retry_cnt_o   out  failed lock attempts in the current sequence (2 bits)
//   lol_cnt_o     out  loss-of-lock event count (8 bits)
// ============================================================================
module gbt_tx_frameclk_pll_ctrl #(
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic       ready_o,
    output logic       error_o,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt_o,
    output logic [7:0] lol_cnt_o
);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAILED    = 3'd4
    } state_e;

    // A single 16-bit timer serves every state. It is cleared on each state
    // change and compared for equality against the last cycle of each phase.
    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  MAX_RETRY    = 2'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  retry_q, retry_d;
    logic [1:0]  sync_q,  sync_d;
    logic        pll_rst_q, pll_rst_d;
    logic        ready_q,   ready_d;
    logic        error_q,   error_d;
    logic        locked_s;

    // Two-flop synchronizer. Only the second stage feeds the FSM.
    assign sync_d   = {sync_q[0], locked_i};
    assign locked_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;

        // The relock request overrides every other transition, including a
        // timeout or a lock loss that lands in the same cycle.
        if (relock_req_i) begin
            state_d = ST_RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_d = '0;
                        retry_d = retry_q + 2'd1;
                        state_d = (retry_d == MAX_RETRY) ? ST_FAILED : ST_RESET_PLL;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_STABLE: begin
                    // A lock glitch sends us back to waiting without spending
                    // a retry; the timeout window starts over.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
                ST_READY: begin
                    if (!locked_s) begin
                        state_d = ST_RESET_PLL;
                        timer_d = '0;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    // Unused codes 5-7 fall back to a fresh reset sequence.
                    state_d = ST_RESET_PLL;
                    timer_d = '0;
                    retry_d = '0;
                end
            endcase
        end

        // The outputs are decoded from the next state, so they change on the
        // same edge as state_o.
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAILED);
        ready_d   = (state_d == ST_READY);
        error_d   = (state_d == ST_FAILED);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            sync_q    <= sync_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

`ifdef GBT_PLL_CTRL_LOL_COUNTER_EN
    logic [7:0] lol_cnt_q, lol_cnt_d;
    logic       lol_event;

    // The event matches the READY->RESET_PLL edge taken above; a relock
    // request in the same cycle suppresses it.
    assign lol_event = (state_q == ST_READY) && !locked_s && !relock_req_i;

    always_comb begin
        lol_cnt_d = lol_cnt_q;
        if (lol_event && (lol_cnt_q != 8'hFF)) begin
            lol_cnt_d = lol_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            lol_cnt_q <= '0;
        end else begin
            lol_cnt_q <= lol_cnt_d;
        end
    end

    assign lol_cnt_o = lol_cnt_q;
`else
    assign lol_cnt_o = '0;
`endif

    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
    assign pll_rst_o   = pll_rst_q;
    assign ready_o     = ready_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_gbt_tx_frameclk_pll_ctrl.sv
// ============================================================================
// tb_gbt_tx_frameclk_pll_ctrl
//
// Bench for gbt_tx_frameclk_pll_ctrl with RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=32 and MAX_RETRIES=3. Each vector holds its inputs for
// a number of cycles and then states the outputs expected at that point.
// The expectations go into a queue tagged with the cycle when they are due,
// and a monitor on the falling edge pops and compares them.
// ============================================================================
module tb_gbt_tx_frameclk_pll_ctrl;

`ifdef GBT_PLL_CTRL_LOL_COUNTER_EN
    localparam bit LOL_EN = 1'b1;
`else
    localparam bit LOL_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked_i = 1'b0;
    logic       relock_req_i = 1'b0;
    logic       pll_rst_o, ready_o, error_o;
    logic [2:0] state_o;
    logic [1:0] retry_cnt_o;
    logic [7:0] lol_cnt_o;

    gbt_tx_frameclk_pll_ctrl #(
        .RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(3)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .locked_i(locked_i),
        .relock_req_i(relock_req_i),
        .pll_rst_o(pll_rst_o),
        .ready_o(ready_o),
        .error_o(error_o),
        .state_o(state_o),
        .retry_cnt_o(retry_cnt_o),
        .lol_cnt_o(lol_cnt_o)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string      name;
        bit         rst;
        bit         locked;
        bit         relock;
        int         cycles;
        int         due;
        logic [2:0] st;
        bit         pll;
        bit         rdy;
        bit         err;
        int         retry;   // -1: not checked
        logic [7:0] lol;     // value with the loss-of-lock counter enabled
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    // Scoreboard monitor: outputs are stable on the falling edge.
    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            vec_t e;
            logic [7:0] lol_exp;
            bit bad;
            e = sb.pop_front();
            lol_exp = LOL_EN ? e.lol : 8'd0;
            n_tests++;
            bad = (e.due != cyc) ||
                  (state_o !== e.st) || (pll_rst_o !== e.pll) ||
                  (ready_o !== e.rdy) || (error_o !== e.err) ||
                  (lol_cnt_o !== lol_exp) ||
                  (e.retry >= 0 && retry_cnt_o !== 2'(e.retry));
            if (bad) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got st=%0d pll=%0b rdy=%0b err=%0b retry=%0d lol=%0d ; want st=%0d pll=%0b rdy=%0b err=%0b retry=%0d lol=%0d (due %0d)",
                         e.name, cyc, state_o, pll_rst_o, ready_o, error_o, retry_cnt_o, lol_cnt_o,
                         e.st, e.pll, e.rdy, e.err, e.retry, lol_exp, e.due);
            end
        end
    end

    function automatic vec_t mk(string n, bit r, bit l, bit q, int c, int st,
                                bit p, bit rd, bit e, int rt, int lo);
        vec_t v;
        v.name = n; v.rst = r; v.locked = l; v.relock = q; v.cycles = c;
        v.due = 0; v.st = 3'(st); v.pll = p; v.rdy = rd; v.err = e;
        v.retry = rt; v.lol = 8'(lo);
        return v;
    endfunction

    // Drive one vector from a falling edge and queue its expectation.
    task automatic apply(input vec_t v);
        vec_t e;
        rst          = v.rst;
        locked_i     = v.locked;
        relock_req_i = v.relock;
        e = v;
        e.due = cyc + v.cycles;
        sb.push_back(e);
        repeat (v.cycles) @(negedge refclk);
    endtask

    initial begin
        //                 name             rst lk rq cyc st pll rdy err rty lol
        tbl.push_back(mk("rst_hold",       1, 0, 0,  2, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("rst_pulse",      0, 0, 0,  3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("rst_pulse_end",  0, 0, 0,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("wait_idle",      0, 0, 0,  5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("lock_sync",      0, 1, 0,  2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("stable_entry",   0, 1, 0,  1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("stable_count",   0, 1, 0,  7, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ready_rise",     0, 1, 0,  1, 3, 0, 1, 0, 0, 0));
        tbl.push_back(mk("lol_sync",       0, 0, 0,  2, 3, 0, 1, 0, 0, 0));
        tbl.push_back(mk("lol_reset",      0, 0, 0,  1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("lol_pulse",      0, 0, 0,  3, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk("lol_wait",       0, 0, 0,  1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("relock_stable",  0, 1, 0,  3, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk("glitch_low",     0, 0, 0,  3, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("glitch_sync",    0, 1, 0,  2, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk("glitch_stable",  0, 1, 0,  1, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk("glitch_count",   0, 1, 0,  7, 2, 0, 0, 0, 0, 1));
        tbl.push_back(mk("glitch_ready",   0, 1, 0,  1, 3, 0, 1, 0, 0, 1));
        tbl.push_back(mk("to_sync",        0, 0, 0,  2, 3, 0, 1, 0, 0, 1));
        tbl.push_back(mk("to_reset0",      0, 0, 0,  1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("to_pulse0",      0, 0, 0,  3, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("to_wait0",       0, 0, 0,  1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk("to_wait0_end",   0, 0, 0, 31, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk("to_retry1",      0, 0, 0,  1, 0, 1, 0, 0, 1, 2));
        tbl.push_back(mk("to_pulse1",      0, 0, 0,  3, 0, 1, 0, 0, 1, 2));
        tbl.push_back(mk("to_wait1",       0, 0, 0,  1, 1, 0, 0, 0, 1, 2));
        tbl.push_back(mk("to_wait1_end",   0, 0, 0, 31, 1, 0, 0, 0, 1, 2));
        tbl.push_back(mk("to_retry2",      0, 0, 0,  1, 0, 1, 0, 0, 2, 2));
        tbl.push_back(mk("to_pulse2",      0, 0, 0,  3, 0, 1, 0, 0, 2, 2));
        tbl.push_back(mk("to_wait2",       0, 0, 0,  1, 1, 0, 0, 0, 2, 2));
        tbl.push_back(mk("to_wait2_end",   0, 0, 0, 31, 1, 0, 0, 0, 2, 2));
        tbl.push_back(mk("failed",         0, 0, 0,  1, 4, 1, 0, 1,-1, 2));
        tbl.push_back(mk("failed_hold",    0, 0, 0, 10, 4, 1, 0, 1,-1, 2));
        tbl.push_back(mk("recover",        0, 0, 1,  1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("rec_pulse",      0, 0, 0,  3, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("rec_wait",       0, 0, 0,  1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk("rec_sync",       0, 1, 0,  2, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk("rec_stable",     0, 1, 0,  1, 2, 0, 0, 0, 0, 2));
        tbl.push_back(mk("rec_count",      0, 1, 0,  7, 2, 0, 0, 0, 0, 2));
        tbl.push_back(mk("rec_ready",      0, 1, 0,  1, 3, 0, 1, 0, 0, 2));
        tbl.push_back(mk("relock_ready",   0, 1, 1,  1, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("rr_pulse",       0, 0, 0,  3, 0, 1, 0, 0, 0, 2));
        tbl.push_back(mk("rr_wait",        0, 0, 0,  1, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk("rr_wait20",      0, 0, 0, 20, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk("rst_mid_wait",   1, 0, 0,  1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("rst_mid_pulse",  0, 0, 0,  3, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("rst_mid_end",    0, 0, 0,  1, 1, 0, 0, 0, 0, 0));

        @(negedge refclk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Relock request in the same cycle the FSM sees lock loss in READY:
        // the restart is not a loss-of-lock event.
        apply(mk("sim_sync",        0, 1, 0,  3, 2, 0, 0, 0, 0, 0));
        apply(mk("sim_ready",       0, 1, 0,  8, 3, 0, 1, 0, 0, 0));
        apply(mk("sim_drop",        0, 0, 0,  2, 3, 0, 1, 0, 0, 0));
        apply(mk("sim_relock_wins", 0, 0, 1,  1, 0, 1, 0, 0, 0, 0));
        apply(mk("sim_pulse",       0, 0, 0,  3, 0, 1, 0, 0, 0, 0));
        apply(mk("sim_wait",        0, 0, 0,  1, 1, 0, 0, 0, 0, 0));

        repeat (3) @(negedge refclk);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
            $fatal(1, "scoreboard not drained");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cyc %0d, want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
